// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: line FSM state encoding and bit-period computation.
// Used by both the TX and RX sides of the UART.
package rs232_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rs232_state_t;

    localparam int HZ_PER_MHZ = 1000000;

    // Clocks per line bit, truncated toward zero.
    function automatic int bit_div(input int mhz_i, input int baud_i);
        return (mhz_i * HZ_PER_MHZ) / baud_i;
    endfunction

endpackage

// File: rtl/rs232_fifo.sv
// Byte FIFO with occupancy count; head is visible combinationally, pop takes effect on the next edge.
// Latency: write visible in count one edge later; a push while full is dropped unless a pop happens that cycle.
module rs232_fifo #(
    parameter int depth = 16,
    parameter int width = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_vld,
    input  logic [width-1:0]       push_dat,
    input  logic                   pop_vld,
    output logic [width-1:0]       head_dat,
    output logic [$clog2(depth):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(depth));
    assign rd_en    = pop_vld && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
    assign wr_en    = push_vld && (!full || rd_en);
    assign overflow = push_vld && full && !rd_en;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rs232_tx_fifo.sv
// Buffered RS-232 8N1 transmitter: bytes queue in a FIFO and are sent back-to-back on a registered TXD.
// Latency: TXD falls on the 2nd edge after a write into an idle, empty path; writes to a full FIFO are dropped with tx_overflow.
module rs232_tx_fifo
    import rs232_pkg::*;
#(
    parameter int baud  = 9600,
    parameter int mhz   = 50,
    parameter int depth = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tx_vld,
    input  logic [7:0]             transmit_data,
    output logic                   tx_full,
    output logic                   tx_overflow,
    output logic [$clog2(depth):0] fifo_count,
    output logic                   tx_busy,
    output logic                   RS232_DCE_TXD
);
    localparam int DIV   = bit_div(mhz, baud);
    localparam int CNT_W = $clog2(DIV + 1);

    rs232_state_t     state_q;
    rs232_state_t     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             txd_q;
    logic             txd_d;
    logic             pop;
    logic             bit_done;
    logic             fifo_empty;
    logic [7:0]       head_dat;

    rs232_fifo #(
        .depth (depth),
        .width (8)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (tx_vld),
        .push_dat (transmit_data),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (tx_full),
        .empty    (fifo_empty),
        .overflow (tx_overflow)
    );

    assign bit_done      = (cnt_q == CNT_W'(DIV - 1));
    assign tx_busy       = (state_q != IDLE);
    assign RS232_DCE_TXD = txd_q;

    // TXD is computed from the next state so the register holds each bit for exactly DIV clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head_dat;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = shift_q[idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head_dat;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule
